// File: rtl/mem_bus_master.sv
// mem_bus_master: bridges core load/store requests onto the shared 64-bit memory bus,
// with lane extraction, sign/zero extension and read-modify-write for partial stores.
// Optional statistics counters are built when MEM_BUS_STATS_EN is defined.
module mem_bus_master #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rw,
    inout  wire  [63:0]       bus_data
`ifdef MEM_BUS_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_reads,
    output logic [CNT_W-1:0]  stat_writes,
    output logic [CNT_W-1:0]  stat_errs
`endif
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_rw_q, bus_rw_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        off_q, off_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              misaligned;
    logic [5:0]        sh;
    logic [7:0]        lane_mask;
    logic [63:0]       shifted, wdata_shl, extended, merged;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'd0) ||
                        (req_size == 2'd3 && req_addr[2:0] != 3'd0);
    assign sh        = {off_q, 3'b000};
    assign shifted   = bus_data >> sh;
    assign wdata_shl = wdata_q << sh;
    assign lane_mask = (size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 :
                        size_q == 2'd2 ? 8'h0f : 8'hff) << off_q;

    // Right-justify the addressed lanes and extend them to 64 bits.
    always_comb begin
        extended = size_q == 2'd0 ? {{56{~uns_q & shifted[7]}},  shifted[7:0]}  :
                   size_q == 2'd1 ? {{48{~uns_q & shifted[15]}}, shifted[15:0]} :
                   size_q == 2'd2 ? {{32{~uns_q & shifted[31]}}, shifted[31:0]} : shifted;
    end

    // Overlay the store bytes onto the doubleword just read for the RMW write-back.
    always_comb begin
        merged = bus_data;
        for (int i = 0; i < 8; i++)
            merged[8*i +: 8] = lane_mask[i] ? wdata_shl[8*i +: 8] : bus_data[8*i +: 8];
    end

    // Next-state and bus/response register updates.
    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        bus_rw_d   = 1'b0;
        we_d       = we_q;
        uns_d      = uns_q;
        err_d      = err_q;
        size_d     = size_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                uns_d   = req_unsigned;
                size_d  = req_size;
                off_d   = req_addr[2:0];
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = misaligned;
                if (misaligned) begin
                    state_d = RESP;
                end else begin
                    bus_addr_d = {req_addr[ADDR_W-1:3], 3'b000};
                    bus_rw_d   = req_we && req_size == 2'd3;
                    state_d    = (req_we && req_size == 2'd3) ? WRITE : READ;
                end
            end
            READ: if (we_q) begin
                state_d  = WRITE;
                bus_rw_d = 1'b1;
                wdata_d  = merged;
            end else begin
                state_d = RESP;
                rdata_d = extended;
            end
            WRITE: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset drops bus_rw at once so no late write occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bus_addr_q <= '0;
            bus_rw_q   <= 1'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= 3'd0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            bus_addr_q <= bus_addr_d;
            bus_rw_q   <= bus_rw_d;
            we_q       <= we_d;
            uns_q      <= uns_d;
            err_q      <= err_d;
            size_q     <= size_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_rw    = bus_rw_q;
    assign bus_data  = bus_rw_q ? wdata_q : 'z;

`ifdef MEM_BUS_STATS_EN
    logic [CNT_W-1:0] reads_q, writes_q, errs_q;

    // Free-running event counters that wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            errs_q   <= '0;
        end else begin
            if (state_q == READ) reads_q <= reads_q + CNT_W'(1);
            if (state_q == WRITE) writes_q <= writes_q + CNT_W'(1);
            if (state_q == IDLE && req_valid && misaligned) errs_q <= errs_q + CNT_W'(1);
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_errs   = errs_q;
`endif
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: vector table, directed corner sequences and random traffic
// checked against a byte-array memory reference model.
module tb_mem_bus_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] bus_addr;
    logic        bus_rw;
    wire  [63:0] bus_data;
`ifdef MEM_BUS_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_errs;
`endif

    mem_bus_master dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_data(bus_data)
`ifdef MEM_BUS_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:15];
    logic [63:0] mem_rd_q = '0;
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [63:0] poke_val = '0;

    assign bus_data = bus_rw ? 64'bz : mem_rd_q;

    always @(negedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (bus_rw) mem[bus_addr[6:3]] <= bus_data;
        else mem_rd_q <= mem[bus_addr[6:3]];
    end

    logic [7:0] ref_mem [0:127];
    int total = 0, bad = 0;
    int exp_reads = 0, exp_writes = 0, exp_errs = 0;

    typedef struct {
        bit          pre;
        int          pidx;
        logic [63:0] pval;
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [6:0]  addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vt [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_dw(input int idx);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[idx*8 + i];
        return r;
    endfunction

    task automatic poke(input int idx, input logic [63:0] v);
        poke_idx = idx[3:0];
        poke_val = v;
        poke_en  = 1'b1;
        @(negedge clk);
        #1 poke_en = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[idx*8 + i] = v[8*i +: 8];
    endtask

    task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [6:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output bit err, output int lat);
        int n;
        n   = 1 << sz;
        rd  = '0;
        err = (int'(a) % n) != 0;
        lat = 0;
        if (err) begin
            exp_errs++;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            lat = n == 8 ? 1 : 2;
            exp_writes++;
            if (n != 8) exp_reads++;
        end else begin
            for (int i = 0; i < n; i++) rd = rd | (64'(ref_mem[int'(a) + i]) << (8*i));
            if (!uns && n < 8 && rd[8*n-1]) rd = rd - (64'd1 << (8*n));
            lat = 1;
            exp_reads++;
        end
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns, input logic [6:0] a,
                          input logic [63:0] wd, output logic [63:0] rd, output bit err, output int lat);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = {57'd0, a}; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rd, erd, keep;
        bit          err, eerr;
        int          lat, elat;

        vt[0]  = '{1, 0, 64'h02000113000000b3, 0, 2'd3, 0, 7'h00, 64'h0, 64'h02000113000000b3, 0, 1};
        vt[1]  = '{1, 0, 64'hfe209ee3000000b3, 0, 2'd2, 0, 7'h04, 64'h0, 64'hfffffffffe209ee3, 0, 1};
        vt[2]  = '{0, 0, 64'h0,                0, 2'd2, 1, 7'h04, 64'h0, 64'h00000000fe209ee3, 0, 1};
        vt[3]  = '{1, 1, 64'hfe209ee300108093, 1, 2'd0, 0, 7'h09, 64'hAA, 64'h0, 0, 2};
        vt[4]  = '{0, 0, 64'h0,                0, 2'd3, 0, 7'h08, 64'h0, 64'hfe209ee30010aa93, 0, 1};
        vt[5]  = '{0, 0, 64'h0,                0, 2'd1, 0, 7'h03, 64'h0, 64'h0, 1, 0};
        vt[6]  = '{0, 0, 64'h0,                0, 2'd0, 0, 7'h09, 64'h0, 64'hffffffffffffffaa, 0, 1};
        vt[7]  = '{0, 0, 64'h0,                0, 2'd0, 1, 7'h09, 64'h0, 64'h00000000000000aa, 0, 1};
        vt[8]  = '{0, 0, 64'h0,                1, 2'd3, 0, 7'h10, 64'h1122334455667788, 64'h0, 0, 1};
        vt[9]  = '{0, 0, 64'h0,                0, 2'd1, 0, 7'h16, 64'h0, 64'h0000000000001122, 0, 1};
        vt[10] = '{0, 0, 64'h0,                1, 2'd2, 0, 7'h14, 64'h00000000deadbeef, 64'h0, 0, 2};
        vt[11] = '{0, 0, 64'h0,                0, 2'd3, 0, 7'h10, 64'h0, 64'hdeadbeef55667788, 0, 1};
        vt[12] = '{0, 0, 64'h0,                0, 2'd1, 0, 7'h14, 64'h0, 64'hffffffffffffbeef, 0, 1};
        vt[13] = '{0, 0, 64'h0,                1, 2'd3, 0, 7'h1c, 64'h5555, 64'h0, 1, 0};
        vt[14] = '{0, 0, 64'h0,                0, 2'd2, 1, 7'h12, 64'h0, 64'h0, 1, 0};
        vt[15] = '{0, 0, 64'h0,                1, 2'd1, 0, 7'h0e, 64'hffff1234, 64'h0, 0, 2};
        vt[16] = '{0, 0, 64'h0,                0, 2'd2, 0, 7'h0c, 64'h0, 64'h0000000012349ee3, 0, 1};

        #12 rst_n = 1'b0;
        #1;
        check("rst_bus_rw", bus_rw, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_bus_rw", bus_rw, 0);

        for (int i = 0; i < 16; i++) poke(i, {$urandom, $urandom});

        for (int v = 0; v < 17; v++) begin
            if (vt[v].pre) poke(vt[v].pidx, vt[v].pval);
            model(vt[v].we, vt[v].sz, vt[v].uns, vt[v].addr, vt[v].wd, erd, eerr, elat);
            keep = mem[vt[v].addr[6:3]];
            do_req(vt[v].we, vt[v].sz, vt[v].uns, vt[v].addr, vt[v].wd, rd, err, lat);
            check($sformatf("vec%0d_rdata", v), rd, vt[v].exp_rd);
            check($sformatf("vec%0d_err", v), 64'(err), 64'(vt[v].exp_err));
            check($sformatf("vec%0d_lat", v), 64'(lat), 64'(vt[v].exp_lat));
            if (vt[v].exp_err) check($sformatf("vec%0d_mem_kept", v), mem[vt[v].addr[6:3]], keep);
            else if (vt[v].we) check($sformatf("vec%0d_mem", v), mem[vt[v].addr[6:3]], ref_dw(int'(vt[v].addr[6:3])));
        end
        check("partial_store_mem1", mem[1], 64'h12349ee30010aa93);

        model(0, 2'd3, 0, 7'h08, 64'h0, erd, eerr, elat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_rsp_valid_rise", rsp_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_rsp_valid", c), rsp_valid, 1);
            check($sformatf("bp%0d_rsp_rdata", c), rsp_rdata, erd);
            check($sformatf("bp%0d_req_ready", c), req_ready, 0);
            check($sformatf("bp%0d_bus_rw", c), bus_rw, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp_release_rsp_valid", rsp_valid, 0);
        check("bp_release_req_ready", req_ready, 1);

        poke(4, 64'h0123456789abcdef);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'h20;
        req_wdata = 64'hcafef00dcafef00d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("wr_enter_bus_rw", bus_rw, 1);
        rst_n = 1'b0;
        #1;
        check("wr_rst_bus_rw", bus_rw, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("wr_rst_mem_kept", mem[4], 64'h0123456789abcdef);
        check("wr_rst_req_ready", req_ready, 1);
        check("wr_rst_rsp_valid", rsp_valid, 0);
        exp_reads = 0; exp_writes = 0; exp_errs = 0;

        for (int k = 0; k < 150; k++) begin
            bit          we, uns;
            logic [1:0]  sz;
            logic [6:0]  a;
            logic [63:0] wd;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~7'((1 << sz) - 1);
            wd  = {$urandom, $urandom};
            model(we, sz, uns, a, wd, erd, eerr, elat);
            do_req(we, sz, uns, a, wd, rd, err, lat);
            check($sformatf("rnd%0d_rdata", k), rd, erd);
            check($sformatf("rnd%0d_err", k), 64'(err), 64'(eerr));
            check($sformatf("rnd%0d_lat", k), 64'(lat), 64'(elat));
        end
        for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_dw(i));
`ifdef MEM_BUS_STATS_EN
        check("stat_reads", 64'(stat_reads), 64'(exp_reads));
        check("stat_writes", 64'(stat_writes), 64'(exp_writes));
        check("stat_errs", 64'(stat_errs), 64'(exp_errs));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
